// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Optional macro DIV_WAIT_EN adds a DIVWAIT state that stalls R-type DIV on an external divider.
module mips_multicycle_ctrl #(
    parameter int DIV_MAX_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       div_done,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       div_start,
    output logic       div_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_DIVWAIT = 4'd12
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       div_start;
    } ctrl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_DIV   = 6'b011010;

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctl;
    logic   r_div_timeout;
    logic   w_timeout;
    logic   w_div_fn;

`ifdef DIV_WAIT_EN
    localparam int CNT_W = (DIV_MAX_CYCLES > 1) ? $clog2(DIV_MAX_CYCLES) : 1;
    logic [CNT_W-1:0] r_div_cnt;
    assign w_div_fn = (funct == FN_DIV);
`else
    logic w_unused;
    assign w_div_fn = 1'b0;
    assign w_unused = ^{funct, div_done, DIV_MAX_CYCLES > 0};
`endif

    // Moore output table, applied to the next state so outputs leave the flops with the state.
    function automatic ctrl_t decode(input state_t s, input logic div_fn);
        decode = '0;
        case (s)
            S_FETCH:   begin decode.ir_write = 1'b1; decode.pc_write = 1'b1; decode.alu_src_b = 2'b01; end
            S_DECODE:  decode.alu_src_b = 2'b11;
            S_MEMADR:  begin decode.alu_src_a = 1'b1; decode.alu_src_b = 2'b10; end
            S_MEMRD:   decode.iord = 1'b1;
            S_MEMWB:   begin decode.reg_write = 1'b1; decode.mem_to_reg = 1'b1; end
            S_MEMWR:   begin decode.iord = 1'b1; decode.mem_write = 1'b1; end
            S_EXEC:    begin decode.alu_src_a = 1'b1; decode.alu_op = 2'b10; decode.div_start = div_fn; end
            S_ALUWB:   begin decode.reg_write = 1'b1; decode.reg_dst = 1'b1; end
            S_BRANCH:  begin
                decode.alu_src_a = 1'b1; decode.alu_op = 2'b01;
                decode.pc_src = 2'b01;   decode.branch = 1'b1;
            end
            S_ADDIEX:  begin decode.alu_src_a = 1'b1; decode.alu_src_b = 2'b10; end
            S_ADDIWB:  decode.reg_write = 1'b1;
            S_JUMP:    begin decode.pc_src = 2'b10; decode.pc_write = 1'b1; end
            S_DIVWAIT: begin decode.alu_src_a = 1'b1; decode.alu_op = 2'b10; end
            default:   decode = '0;
        endcase
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns every variable; no latches inferred.
        w_next    = S_FETCH;
        w_timeout = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = w_div_fn ? S_DIVWAIT : S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
`ifdef DIV_WAIT_EN
            S_DIVWAIT: begin
                if (div_done) begin
                    w_next = S_ALUWB;
                end else if (r_div_cnt == CNT_W'(DIV_MAX_CYCLES - 1)) begin
                    w_next    = S_FETCH;
                    w_timeout = 1'b1;
                end else begin
                    w_next = S_DIVWAIT;
                end
            end
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // NOTE: state and registered outputs update with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_ctl         <= decode(S_FETCH, 1'b0);
            r_div_timeout <= 1'b0;
`ifdef DIV_WAIT_EN
            r_div_cnt     <= '0;
`endif
        end else begin
            r_state       <= w_next;
            r_ctl         <= decode(w_next, w_div_fn);
            r_div_timeout <= w_timeout;
`ifdef DIV_WAIT_EN
            if (r_state == S_DIVWAIT && w_next == S_DIVWAIT)
                r_div_cnt <= r_div_cnt + 1'b1;
            else
                r_div_cnt <= '0;
`endif
        end
    end

    // The flops hold FETCH's controls through reset; gating by reset blanks every strobe
    // while asserted and lets FETCH act in the very first cycle after release.
    assign pc_en       = (r_ctl.pc_write | (r_ctl.branch & zero)) & ~reset;
    assign iord        = r_ctl.iord       & ~reset;
    assign mem_write   = r_ctl.mem_write  & ~reset;
    assign ir_write    = r_ctl.ir_write   & ~reset;
    assign reg_dst     = r_ctl.reg_dst    & ~reset;
    assign mem_to_reg  = r_ctl.mem_to_reg & ~reset;
    assign reg_write   = r_ctl.reg_write  & ~reset;
    assign alu_src_a   = r_ctl.alu_src_a  & ~reset;
    assign alu_src_b   = r_ctl.alu_src_b  & {2{~reset}};
    assign alu_op      = r_ctl.alu_op     & {2{~reset}};
    assign pc_src      = r_ctl.pc_src     & {2{~reset}};
    assign div_start   = r_ctl.div_start  & ~reset;
    assign div_timeout = r_div_timeout    & ~reset;
    assign state       = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares. DIV tests are compiled in when DIV_WAIT_EN is defined.
module tb_mips_multicycle_ctrl;

`ifdef DIV_WAIT_EN
    localparam int MAXC = 8;
`else
    localparam int MAXC = 64;
`endif

    typedef struct packed {
        logic [3:0] state;
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       div_start;
        logic       div_timeout;
    } obs_t;

    localparam obs_t E_RST      = '0;
    localparam obs_t E_FETCH    = '{state: 4'd0, pc_en: 1'b1, ir_write: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam obs_t E_FETCH_TO = '{state: 4'd0, pc_en: 1'b1, ir_write: 1'b1, alu_src_b: 2'b01, div_timeout: 1'b1, default: '0};
    localparam obs_t E_DECODE   = '{state: 4'd1, alu_src_b: 2'b11, default: '0};
    localparam obs_t E_MEMADR   = '{state: 4'd2, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
    localparam obs_t E_MEMRD    = '{state: 4'd3, iord: 1'b1, default: '0};
    localparam obs_t E_MEMWB    = '{state: 4'd4, reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
    localparam obs_t E_MEMWR    = '{state: 4'd5, iord: 1'b1, mem_write: 1'b1, default: '0};
    localparam obs_t E_EXEC     = '{state: 4'd6, alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
    localparam obs_t E_EXEC_DIV = '{state: 4'd6, alu_src_a: 1'b1, alu_op: 2'b10, div_start: 1'b1, default: '0};
    localparam obs_t E_ALUWB    = '{state: 4'd7, reg_write: 1'b1, reg_dst: 1'b1, default: '0};
    localparam obs_t E_BR_T     = '{state: 4'd8, pc_en: 1'b1, alu_src_a: 1'b1, alu_op: 2'b01, pc_src: 2'b01, default: '0};
    localparam obs_t E_BR_NT    = '{state: 4'd8, alu_src_a: 1'b1, alu_op: 2'b01, pc_src: 2'b01, default: '0};
    localparam obs_t E_ADDIEX   = '{state: 4'd9, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
    localparam obs_t E_ADDIWB   = '{state: 4'd10, reg_write: 1'b1, default: '0};
    localparam obs_t E_JUMP     = '{state: 4'd11, pc_en: 1'b1, pc_src: 2'b10, default: '0};
    localparam obs_t E_DIVW     = '{state: 4'd12, alu_src_a: 1'b1, alu_op: 2'b10, default: '0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       div_done = 1'b0;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       div_start, div_timeout;
    logic [3:0] state;

    int    total = 0;
    int    bad = 0;
    obs_t  exp_q[$];
    string name_q[$];
    string tag = "init";

    mips_multicycle_ctrl #(.DIV_MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .div_done(div_done), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .div_start(div_start),
        .div_timeout(div_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (state got %0d want %0d)", nm, act, exp, act.state, exp.state);
        end
    endtask

    task automatic push(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Push one cycle's expectation, then advance to just after the next rising edge.
    task automatic step(input obs_t e);
        push(e, tag);
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample outputs mid-cycle and compare against the scoreboard head.
    initial begin
        obs_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                act = {state, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_op, pc_src, div_start, div_timeout};
                check(name_q.pop_front(), act, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        tag = "reset"; step(E_RST); step(E_RST);
        reset = 1'b0;

        tag = "lw"; opcode = 6'b100011;
        step(E_FETCH); step(E_DECODE); step(E_MEMADR); step(E_MEMRD); step(E_MEMWB);

        tag = "sw"; opcode = 6'b101011;
        step(E_FETCH); step(E_DECODE); step(E_MEMADR); step(E_MEMWR);

        tag = "add"; opcode = 6'b000000; funct = 6'b100000;
        step(E_FETCH); step(E_DECODE); step(E_EXEC); step(E_ALUWB);

        tag = "addi"; opcode = 6'b001000;
        step(E_FETCH); step(E_DECODE); step(E_ADDIEX); step(E_ADDIWB);

        tag = "beq_taken"; opcode = 6'b000100; zero = 1'b1;
        step(E_FETCH); step(E_DECODE); step(E_BR_T);

        tag = "beq_not"; zero = 1'b0;
        step(E_FETCH); step(E_DECODE); step(E_BR_NT);

        tag = "j"; opcode = 6'b000010; zero = 1'b1;
        step(E_FETCH); step(E_DECODE); step(E_JUMP);
        zero = 1'b0;

        tag = "nop_op"; opcode = 6'b111111;
        step(E_FETCH); step(E_DECODE);

`ifdef DIV_WAIT_EN
        tag = "div_done"; opcode = 6'b000000; funct = 6'b011010;
        step(E_FETCH); step(E_DECODE); step(E_EXEC_DIV);
        repeat (4) step(E_DIVW);
        div_done = 1'b1; step(E_DIVW);
        div_done = 1'b0; step(E_ALUWB);

        tag = "div_timeout";
        step(E_FETCH); step(E_DECODE); step(E_EXEC_DIV);
        repeat (MAXC) step(E_DIVW);
        step(E_FETCH_TO);
        opcode = 6'b111111; step(E_DECODE);

        tag = "div_done_at_limit"; opcode = 6'b000000;
        step(E_FETCH); step(E_DECODE); step(E_EXEC_DIV);
        repeat (MAXC - 1) step(E_DIVW);
        div_done = 1'b1; step(E_DIVW);
        div_done = 1'b0; step(E_ALUWB);
`else
        tag = "div_plain"; opcode = 6'b000000; funct = 6'b011010; div_done = 1'b1;
        step(E_FETCH); step(E_DECODE); step(E_EXEC); step(E_ALUWB);
        div_done = 1'b0;
`endif

        tag = "reset_mid_memrd"; opcode = 6'b100011;
        step(E_FETCH); step(E_DECODE); step(E_MEMADR);
        push(E_MEMRD, tag);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(E_RST);
        reset = 1'b0;

        tag = "lw_after_reset";
        step(E_FETCH); step(E_DECODE); step(E_MEMADR); step(E_MEMRD); step(E_MEMWB);
        tag = "fetch_again"; opcode = 6'b111111;
        step(E_FETCH);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
